// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: default geometry of the
// vector table and the request-handshake state encoding.
package irq_pkg;

  localparam int unsigned N_IRQ_DEF      = 8;
  localparam int unsigned VEC_W_DEF      = 10;
  localparam logic [9:0]  VEC_BASE_DEF   = 10'h3C0;
  localparam int unsigned VEC_STRIDE_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_SETTLE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder: idx_o is the position of the lowest set
// bit of req_i; valid_o says whether any bit is set (idx_o is 0 otherwise).
module prio_enc #(
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/irq_controller.sv
// Prioritised, nestable interrupt controller: synchronises and edge-detects the
// raw lines, masks and prioritises them, and hands one vector at a time to the CU.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned      N_IRQ      = N_IRQ_DEF,
  parameter int unsigned      VEC_W      = VEC_W_DEF,
  parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(VEC_BASE_DEF),
  parameter int unsigned      VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] int_e,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             ack,
  input  logic             reti,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vec,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service,
  output logic [N_IRQ-1:0] mask
);

  localparam int unsigned ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0] sync1_q, sync2_q, prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] in_service_q, in_service_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] rise, cand_req, ack_set, reti_clr;

  irq_state_e       state_q, state_d;
  logic             req_q, req_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic             cand_valid, cur_valid;
  logic [ID_W-1:0]  cand_idx, cur_idx;
  logic             eligible, id_live, take;

  function automatic logic [VEC_W-1:0] vec_of(input logic [ID_W-1:0] idx);
    return VEC_BASE + VEC_W'(VEC_STRIDE) * VEC_W'(idx);
  endfunction

  assign rise     = sync2_q & ~prev_q;
  assign cand_req = pending_q & mask_q;

  prio_enc #(.W(N_IRQ), .IDX_W(ID_W)) u_cand (
    .req_i   (cand_req),
    .valid_o (cand_valid),
    .idx_o   (cand_idx)
  );

  prio_enc #(.W(N_IRQ), .IDX_W(ID_W)) u_cur (
    .req_i   (in_service_q),
    .valid_o (cur_valid),
    .idx_o   (cur_idx)
  );

  // Strict preemption: only a strictly higher priority than the running level.
  assign eligible = cand_valid && (!cur_valid || (cand_idx < cur_idx));
  assign id_live  = mask_q[id_q] && pending_q[id_q] && (!cur_valid || (id_q < cur_idx));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (eligible) state_d = ST_REQ;
      ST_REQ: begin
        if (ack)           state_d = ST_SETTLE;
        else if (!id_live) state_d = ST_IDLE;
      end
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;
    vec_d = vec_q;
    id_d  = id_q;
    take  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (eligible) begin
          req_d = 1'b1;
          vec_d = vec_of(cand_idx);
          id_d  = cand_idx;
        end
      end
      ST_REQ: begin
        if (ack) begin
          take  = 1'b1;
          req_d = 1'b0;
        end else if (!id_live) begin
          req_d = 1'b0;
        end else if (eligible && (cand_idx < id_q)) begin
          vec_d = vec_of(cand_idx);
          id_d  = cand_idx;
        end
      end
      default: req_d = 1'b0;
    endcase
  end

  // reti retires the current level before ack adds the new one; a fresh edge
  // on the acknowledged line wins over its clear.
  always_comb begin
    ack_set  = '0;
    reti_clr = '0;
    if (take)              ack_set[id_q]     = 1'b1;
    if (reti && cur_valid) reti_clr[cur_idx] = 1'b1;
    pending_d    = (pending_q & ~ack_set) | rise;
    in_service_d = (in_service_q & ~reti_clr) | ack_set;
    mask_d       = mask_we ? mask_wdata : mask_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      vec_q   <= VEC_BASE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      vec_q   <= vec_d;
      id_q    <= id_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '0;
    end else begin
      sync1_q      <= int_e;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
    end
  end

  assign int_req    = req_q;
  assign int_vec    = vec_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign mask       = mask_q;

endmodule
